// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: column/row counters, porch-accurate
// sync pulses, active-video flag and line/frame start strobes, all registered.
module vga_timing_gen #(
    parameter int ACTIVE_COLS = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int ACTIVE_ROWS = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0,
    parameter int COUNT_W     = 10
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_En,
    output logic [COUNT_W-1:0] o_Col_Count,
    output logic [COUNT_W-1:0] o_Row_Count,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Active,
    output logic               o_Line_Start,
    output logic               o_Frame_Start
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_BEG = ACTIVE_COLS + H_FP;
    localparam int H_SYNC_END = ACTIVE_COLS + H_FP + H_SYNC;
    localparam int V_SYNC_BEG = ACTIVE_ROWS + V_FP;
    localparam int V_SYNC_END = ACTIVE_ROWS + V_FP + V_SYNC;

    localparam logic [COUNT_W-1:0] COL_LAST = COUNT_W'(TOTAL_COLS - 1);
    localparam logic [COUNT_W-1:0] ROW_LAST = COUNT_W'(TOTAL_ROWS - 1);

    localparam logic H_ACT  = (H_POL != 0);
    localparam logic V_ACT  = (V_POL != 0);
    localparam logic H_IDLE = ~H_ACT;
    localparam logic V_IDLE = ~V_ACT;

    // Reject configurations the counters cannot represent or that have no sync pulse.
    generate
        if (COUNT_W < 1 || COUNT_W > 30 ||
            ACTIVE_COLS < 1 || ACTIVE_ROWS < 1 ||
            H_SYNC < 1 || V_SYNC < 1 ||
            H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 ||
            (TOTAL_COLS - 1) >= (1 << COUNT_W) ||
            (TOTAL_ROWS - 1) >= (1 << COUNT_W)) begin : g_bad_cfg
            $error("vga_timing_gen: invalid timing parameters or COUNT_W too small");
        end
    endgenerate

    // Comparisons are done in int so that a region bound equal to 2**COUNT_W
    // (zero back porch at a power-of-two total) cannot wrap.
    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic h_sync_level(input logic [COUNT_W-1:0] c);
        return in_range(int'(c), H_SYNC_BEG, H_SYNC_END) ? H_ACT : H_IDLE;
    endfunction

    function automatic logic v_sync_level(input logic [COUNT_W-1:0] r);
        return in_range(int'(r), V_SYNC_BEG, V_SYNC_END) ? V_ACT : V_IDLE;
    endfunction

    function automatic logic is_active(input logic [COUNT_W-1:0] c,
                                       input logic [COUNT_W-1:0] r);
        return (int'(c) < ACTIVE_COLS) && (int'(r) < ACTIVE_ROWS);
    endfunction

    // Reset release is synchronised: counting starts only once the chain fills.
    logic [1:0] rel_sync;
    logic       run;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rel_sync <= 2'b00;
        end else begin
            rel_sync <= {rel_sync[0], 1'b1};
        end
    end

    assign run = rel_sync[1];

    logic               adv;
    logic               col_wrap;
    logic [COUNT_W-1:0] col_nxt;
    logic [COUNT_W-1:0] row_nxt;

    always_comb begin
        adv      = i_En & run;
        col_wrap = (o_Col_Count == COL_LAST);
        col_nxt  = o_Col_Count;
        row_nxt  = o_Row_Count;
        if (adv) begin
            col_nxt = col_wrap ? '0 : o_Col_Count + 1'b1;
            if (col_wrap) begin
                row_nxt = (o_Row_Count == ROW_LAST) ? '0 : o_Row_Count + 1'b1;
            end
        end
    end

    // Flags are decoded from the next-state counters so they line up with them.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Col_Count   <= COL_LAST;
            o_Row_Count   <= ROW_LAST;
            o_HSync       <= H_IDLE;
            o_VSync       <= V_IDLE;
            o_Active      <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Col_Count   <= col_nxt;
            o_Row_Count   <= row_nxt;
            o_HSync       <= h_sync_level(col_nxt);
            o_VSync       <= v_sync_level(row_nxt);
            o_Active      <= is_active(col_nxt, row_nxt);
            o_Line_Start  <= adv && (col_nxt == '0);
            o_Frame_Start <= adv && (col_nxt == '0) && (row_nxt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen: three configurations checked every
// cycle against a linear pixel-index reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en;

    logic [9:0]  col0, row0;
    logic [10:0] col1, row1;
    logic [3:0]  col2, row2;
    logic hs0, vs0, act0, ls0, fs0;
    logic hs1, vs1, act1, ls1, fs1;
    logic hs2, vs2, act2, ls2, fs2;

    vga_timing_gen u_def (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en),
        .o_Col_Count(col0), .o_Row_Count(row0), .o_HSync(hs0), .o_VSync(vs0),
        .o_Active(act0), .o_Line_Start(ls0), .o_Frame_Start(fs0)
    );

    vga_timing_gen #(
        .ACTIVE_COLS(800), .H_FP(40), .H_SYNC(128), .H_BP(88), .H_POL(1), .COUNT_W(11)
    ) u_big (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en),
        .o_Col_Count(col1), .o_Row_Count(row1), .o_HSync(hs1), .o_VSync(vs1),
        .o_Active(act1), .o_Line_Start(ls1), .o_Frame_Start(fs1)
    );

    vga_timing_gen #(
        .ACTIVE_COLS(8), .H_FP(0), .H_SYNC(3), .H_BP(3),
        .ACTIVE_ROWS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(1), .COUNT_W(4)
    ) u_small (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_En(en),
        .o_Col_Count(col2), .o_Row_Count(row2), .o_HSync(hs2), .o_VSync(vs2),
        .o_Active(act2), .o_Line_Start(ls2), .o_Frame_Start(fs2)
    );

    // Timing of each configuration, indexed 0 = default, 1 = big, 2 = small.
    int ac[3], hfp[3], hsy[3], hbp[3], ar[3], vfp[3], vsy[3], vbp[3], hpol[3], vpol[3];
    int pix[3];
    bit exp_ls[3], exp_fs[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tcols(input int k);
        return ac[k] + hfp[k] + hsy[k] + hbp[k];
    endfunction

    function automatic int trows(input int k);
        return ar[k] + vfp[k] + vsy[k] + vbp[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pix[k]    = tcols(k) * trows(k) - 1;
            exp_ls[k] = 1'b0;
            exp_fs[k] = 1'b0;
        end
    endtask

    // The raster is a single linear pixel index; row/col are its quotient/remainder.
    task automatic model_step(input bit adv);
        for (int k = 0; k < 3; k++) begin
            if (adv) pix[k] = (pix[k] + 1) % (tcols(k) * trows(k));
            exp_ls[k] = adv && (pix[k] % tcols(k) == 0);
            exp_fs[k] = adv && (pix[k] == 0);
        end
    endtask

    task automatic check_inst(input int k, input int col, input int row, input int hs,
                              input int vs, input int act, input int ls, input int fs);
        int c, r, ehs, evs;
        c   = pix[k] % tcols(k);
        r   = pix[k] / tcols(k);
        ehs = (c >= ac[k] + hfp[k] && c < ac[k] + hfp[k] + hsy[k]) ? hpol[k] : 1 - hpol[k];
        evs = (r >= ar[k] + vfp[k] && r < ar[k] + vfp[k] + vsy[k]) ? vpol[k] : 1 - vpol[k];
        chk($sformatf("col[%0d]", k), col, c);
        chk($sformatf("row[%0d]", k), row, r);
        chk($sformatf("hsync[%0d]@col%0d", k, c), hs, ehs);
        chk($sformatf("vsync[%0d]@row%0d", k, r), vs, evs);
        chk($sformatf("active[%0d]@%0d,%0d", k, c, r), act, int'(c < ac[k] && r < ar[k]));
        chk($sformatf("line_start[%0d]", k), ls, int'(exp_ls[k]));
        chk($sformatf("frame_start[%0d]", k), fs, int'(exp_fs[k]));
    endtask

    task automatic check_all();
        check_inst(0, int'(col0), int'(row0), int'(hs0), int'(vs0), int'(act0), int'(ls0), int'(fs0));
        check_inst(1, int'(col1), int'(row1), int'(hs1), int'(vs1), int'(act1), int'(ls1), int'(fs1));
        check_inst(2, int'(col2), int'(row2), int'(hs2), int'(vs2), int'(act2), int'(ls2), int'(fs2));
    endtask

    // Called at a falling edge: drive enable, let one rising edge pass, check.
    task automatic cyc(input bit e, input bit adv);
        en = e;
        @(posedge clk);
        model_step(adv);
        @(negedge clk);
        check_all();
    endtask

    // Release reset; the first edge after release must not advance even with en=1,
    // then enable is held low long enough for any internal release logic to settle.
    task automatic start_seq();
        rst_n = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic random_run(input int n);
        bit e;
        for (int i = 0; i < n; i++) begin
            e = ($urandom_range(0, 3) != 0);
            cyc(e, e);
        end
    endtask

    initial begin
        ac  = '{640, 800, 8};  hfp = '{16, 40, 0};  hsy = '{96, 128, 3}; hbp = '{48, 88, 3};
        ar  = '{480, 480, 6};  vfp = '{10, 10, 1};  vsy = '{2, 2, 2};    vbp = '{33, 33, 1};
        hpol = '{0, 1, 0};     vpol = '{0, 0, 1};

        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();

        start_seq();
        // First advance after reset lands on (0,0) with both strobes and Active.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        random_run(4000);

        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b0);
        end

        random_run(500);

        // Asynchronous reset mid-line: outputs must return before the next clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all();

        start_seq();
        random_run(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
